// File: rtl/chronos_bp_pkg.sv
// Shared types, encodings and helpers for the ChronosCore branch predictor.
// Pure package: no latency, no flow control.
package chronos_bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'd0;
  localparam ctr_t CTR_WNT = 2'd1;
  localparam ctr_t CTR_WT  = 2'd2;
  localparam ctr_t CTR_ST  = 2'd3;

  localparam ctr_t BIM_RST_VAL = CTR_WNT;
  localparam ctr_t GSH_RST_VAL = CTR_WNT;
  localparam ctr_t CHO_RST_VAL = CTR_WNT;

  function automatic ctr_t sat_inc(input ctr_t c);
    return (c == CTR_ST) ? c : ctr_t'(c + 2'd1);
  endfunction

  function automatic ctr_t sat_dec(input ctr_t c);
    return (c == CTR_SNT) ? c : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Array of 2-bit saturating counters: combinational read, read-before-write update.
// Read latency 0, update lands on the next edge; no backpressure (always accepts).
module bp_counter_table
  import chronos_bp_pkg::*;
#(
  parameter int   IDX_BITS = 8,
  parameter ctr_t RST_VAL  = CTR_WNT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rd_idx,
  output ctr_t                rd_ctr,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_inc,
  output ctr_t                wr_old
);

  localparam int DEPTH = 1 << IDX_BITS;

  ctr_t tbl [DEPTH];

  assign rd_ctr = tbl[rd_idx];
  assign wr_old = tbl[wr_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= RST_VAL;
    end else if (wr_en) begin
      tbl[wr_idx] <= wr_inc ? sat_inc(wr_old) : sat_dec(wr_old);
    end
  end

endmodule

// File: rtl/hybrid_branch_pred.sv
// Tournament (bimodal/gshare/chooser) predictor with direct-mapped BTB; optional stats via CHRONOS_BP_STATS_EN.
// Lookup is zero-cycle combinational; training lands on the next edge.
// No backpressure: lookups and resolved-branch updates are accepted every cycle.
module hybrid_branch_pred
  import chronos_bp_pkg::*;
#(
  parameter int BIM_IDX_BITS = 8,
  parameter int GSH_IDX_BITS = 8,
  parameter int GHR_BITS     = 8,
  parameter int CHO_IDX_BITS = 8,
  parameter int BTB_IDX_BITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         fetch_addr,
  input  logic                fetch_req,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_en,
  input  logic [31:0]         upd_pc,
  input  logic                upd_taken,
  input  logic [31:0]         upd_target,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_pred_taken,
  output logic [31:0]         stat_updates,
  output logic [31:0]         stat_mispred
);

  localparam int BTB_DEPTH = 1 << BTB_IDX_BITS;
  localparam int TAG_BITS  = 30 - BTB_IDX_BITS;

  logic [GHR_BITS-1:0] ghr;
  ctr_t bim_rd, gsh_rd, cho_rd, bim_old, gsh_old, cho_old_unused;
  logic bim_ok, gsh_ok;

  logic [GSH_IDX_BITS-1:0] gsh_rd_idx, gsh_wr_idx;
  assign gsh_rd_idx = fetch_addr[GSH_IDX_BITS+1:2] ^ GSH_IDX_BITS'(ghr);
  assign gsh_wr_idx = upd_pc[GSH_IDX_BITS+1:2] ^ GSH_IDX_BITS'(upd_ghr);

  bp_counter_table #(.IDX_BITS(BIM_IDX_BITS), .RST_VAL(BIM_RST_VAL)) u_bim (
    .clk(clk), .rst(rst),
    .rd_idx(fetch_addr[BIM_IDX_BITS+1:2]), .rd_ctr(bim_rd),
    .wr_en(upd_en), .wr_idx(upd_pc[BIM_IDX_BITS+1:2]), .wr_inc(upd_taken), .wr_old(bim_old)
  );

  bp_counter_table #(.IDX_BITS(GSH_IDX_BITS), .RST_VAL(GSH_RST_VAL)) u_gsh (
    .clk(clk), .rst(rst),
    .rd_idx(gsh_rd_idx), .rd_ctr(gsh_rd),
    .wr_en(upd_en), .wr_idx(gsh_wr_idx), .wr_inc(upd_taken), .wr_old(gsh_old)
  );

  // Chooser only moves when exactly one component was right; toward gshare if it was.
  assign bim_ok = (bim_old[1] == upd_taken);
  assign gsh_ok = (gsh_old[1] == upd_taken);

  bp_counter_table #(.IDX_BITS(CHO_IDX_BITS), .RST_VAL(CHO_RST_VAL)) u_cho (
    .clk(clk), .rst(rst),
    .rd_idx(fetch_addr[CHO_IDX_BITS+1:2]), .rd_ctr(cho_rd),
    .wr_en(upd_en && (bim_ok != gsh_ok)), .wr_idx(upd_pc[CHO_IDX_BITS+1:2]),
    .wr_inc(gsh_ok), .wr_old(cho_old_unused)
  );

  logic                    btb_vld [BTB_DEPTH];
  logic [TAG_BITS-1:0]     btb_tag [BTB_DEPTH];
  logic [31:0]             btb_tgt [BTB_DEPTH];
  logic [BTB_IDX_BITS-1:0] f_btb_idx, u_btb_idx;
  logic                    btb_hit;
  ctr_t                    chosen;

  assign f_btb_idx = fetch_addr[BTB_IDX_BITS+1:2];
  assign u_btb_idx = upd_pc[BTB_IDX_BITS+1:2];
  assign btb_hit   = fetch_req && btb_vld[f_btb_idx] &&
                     (btb_tag[f_btb_idx] == fetch_addr[31:BTB_IDX_BITS+2]);
  assign chosen    = cho_rd[1] ? gsh_rd : bim_rd;

  assign pred_valid  = btb_hit;
  assign pred_taken  = btb_hit && chosen[1];
  assign pred_target = btb_hit ? btb_tgt[f_btb_idx] : 32'd0;
  assign pred_ghr    = ghr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) btb_vld[i] <= 1'b0;
    end else if (upd_en) begin
      ghr <= {ghr[GHR_BITS-2:0], upd_taken};
      if (upd_taken) btb_vld[u_btb_idx] <= 1'b1;
    end
  end

  // Tag/target payload needs no reset: it is qualified by btb_vld.
  always_ff @(posedge clk) begin
    if (!rst && upd_en && upd_taken) begin
      btb_tag[u_btb_idx] <= upd_pc[31:BTB_IDX_BITS+2];
      btb_tgt[u_btb_idx] <= upd_target;
    end
  end

`ifdef CHRONOS_BP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_updates <= '0;
      stat_mispred <= '0;
    end else if (upd_en) begin
      if (stat_updates != 32'hFFFF_FFFF) stat_updates <= stat_updates + 32'd1;
      if ((upd_pred_taken != upd_taken) && (stat_mispred != 32'hFFFF_FFFF))
        stat_mispred <= stat_mispred + 32'd1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{fetch_addr[1:0], upd_pc[1:0], cho_old_unused};
`else
  assign stat_updates = 32'd0;
  assign stat_mispred = 32'd0;

  logic unused_bits;
  assign unused_bits = ^{fetch_addr[1:0], upd_pc[1:0], cho_old_unused, upd_pred_taken};
`endif

endmodule

// File: tb/tb_hybrid_branch_pred.sv
// Directed bench for hybrid_branch_pred with hand-computed expectations.
module tb_hybrid_branch_pred;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_addr;
  logic        fetch_req;
  logic        pred_valid, pred_taken;
  logic [31:0] pred_target;
  logic [7:0]  pred_ghr;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [7:0]  upd_ghr;
  logic        upd_pred_taken;
  logic [31:0] stat_updates, stat_mispred;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hybrid_branch_pred dut (
    .clk(clk), .rst(rst),
    .fetch_addr(fetch_addr), .fetch_req(fetch_req),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_ghr(pred_ghr),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_ghr(upd_ghr), .upd_pred_taken(upd_pred_taken),
    .stat_updates(stat_updates), .stat_mispred(stat_mispred)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic [7:0] g, input logic pt);
    @(negedge clk);
    upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_ghr = g; upd_pred_taken = pt;
    upd_en = 1'b1;
    @(negedge clk);
    upd_en = 1'b0;
  endtask

  task automatic look(input logic [31:0] addr, input logic req);
    @(negedge clk);
    fetch_addr = addr;
    fetch_req  = req;
    #1;
  endtask

  initial begin
    rst = 1'b0; fetch_addr = '0; fetch_req = 1'b0;
    upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_ghr = '0; upd_pred_taken = 1'b0;

    // Reset state
    do_reset();
    look(32'h100, 1'b1);
    chk("rst_valid", 32'(pred_valid), 0);
    chk("rst_taken", 32'(pred_taken), 0);
    chk("rst_target", pred_target, 0);
    chk("rst_ghr", 32'(pred_ghr), 0);

    // Two taken updates: bimodal 1->3, chooser stays on bimodal
    upd(32'h100, 1'b1, 32'h200, 8'h00, 1'b0);
    upd(32'h100, 1'b1, 32'h200, 8'h00, 1'b0);
    look(32'h100, 1'b1);
    chk("two_upd_valid", 32'(pred_valid), 1);
    chk("two_upd_taken", 32'(pred_taken), 1);
    chk("two_upd_target", pred_target, 32'h200);
    chk("two_upd_ghr", 32'(pred_ghr), 32'h03);

    // Five more taken then one not-taken: bimodal ends at 2
    for (int i = 0; i < 5; i++) upd(32'h100, 1'b1, 32'h200, 8'h00, 1'b1);
    upd(32'h100, 1'b0, 32'h0, 8'h00, 1'b1);
    look(32'h100, 1'b1);
    chk("wt_taken", 32'(pred_taken), 1);
    chk("wt_ghr", 32'(pred_ghr), 32'hFE);

    // Same-cycle not-taken update and lookup: read-before-write
    @(negedge clk);
    fetch_addr = 32'h100; fetch_req = 1'b1;
    upd_pc = 32'h100; upd_taken = 1'b0; upd_target = '0; upd_ghr = '0;
    upd_pred_taken = 1'b1; upd_en = 1'b1;
    #1;
    chk("rbw_same_cycle", 32'(pred_taken), 1);
    @(negedge clk);
    upd_en = 1'b0;
    #1;
    chk("rbw_next_cycle", 32'(pred_taken), 0);
    chk("rbw_still_valid", 32'(pred_valid), 1);
    chk("rbw_ghr", 32'(pred_ghr), 32'hFC);

    // fetch_req=0 suppresses outputs
    look(32'h100, 1'b0);
    chk("noreq_valid", 32'(pred_valid), 0);
    chk("noreq_target", pred_target, 0);

    // Reset together with an update: update is dropped
    @(negedge clk);
    rst = 1'b1;
    upd_pc = 32'h180; upd_taken = 1'b1; upd_target = 32'h300; upd_ghr = '0; upd_en = 1'b1;
    @(negedge clk);
    rst = 1'b0; upd_en = 1'b0;
    look(32'h100, 1'b1);
    chk("rstupd_valid_100", 32'(pred_valid), 0);
    look(32'h180, 1'b1);
    chk("rstupd_valid_180", 32'(pred_valid), 0);
    chk("rstupd_ghr", 32'(pred_ghr), 0);

    // Alternating T/N at 0x40: bimodal always wrong, gshare learns, chooser moves to gshare
    for (int i = 0; i < 64; i++) begin
      logic pt;
      logic [7:0] g;
      logic act;
      act = (i % 2 == 0);
      @(negedge clk);
      fetch_addr = 32'h40; fetch_req = 1'b1;
      #1;
      pt = pred_taken;
      g  = pred_ghr;
      upd_pc = 32'h40; upd_taken = act; upd_target = 32'h80;
      upd_ghr = g; upd_pred_taken = pt; upd_en = 1'b1;
      if (i >= 56) chk($sformatf("alt_pred_%0d", i), 32'(pt), 32'(act));
      @(posedge clk);
      #1;
      upd_en = 1'b0;
    end
    look(32'h40, 1'b1);
    chk("alt_target", pred_target, 32'h80);
    chk("alt_ghr", 32'(pred_ghr), 32'hAA);

    // Same BTB index, different tag: miss
    look(32'hC0, 1'b1);
    chk("tag_miss_valid", 32'(pred_valid), 0);

    // Statistics
    do_reset();
    for (int i = 0; i < 10; i++) begin
      logic tk;
      tk = (i % 3 == 0);
      upd(32'h200, tk, 32'h400, 8'h00, (i == 1 || i == 4 || i == 7) ? ~tk : tk);
    end
    look(32'h0, 1'b0);
`ifdef CHRONOS_BP_STATS_EN
    chk("stat_updates", stat_updates, 10);
    chk("stat_mispred", stat_mispred, 3);
`else
    chk("stat_updates_off", stat_updates, 0);
    chk("stat_mispred_off", stat_mispred, 0);
`endif
    do_reset();
    #1;
    chk("stat_updates_rst", stat_updates, 0);
    chk("stat_mispred_rst", stat_mispred, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
